// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: prescaled digit scan, one-cold anodes,
// hex decode, per-digit dp/blanking, PWM brightness and frame-aligned double buffering.
module seg_scan_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 100000,
    parameter int DUTY_BITS  = 3,
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [DUTY_BITS-1:0]    brightness,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_done,
    output logic                    load_ack
);

    localparam int PROD_W = DUTY_BITS + 33;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        div_cnt;
    logic                    slot_end;
    logic                    wrap;

    // Buffers hold a "lit" mask (inverse of blank_mask) so cleared buffers are dark.
    logic [4*NUM_DIGITS-1:0] pend_value;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_lit;
    logic                    pend_valid;
    logic [4*NUM_DIGITS-1:0] disp_value;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   disp_lit;

    logic [PROD_W-1:0]       on_prod;
    logic [PROD_W-1:0]       on_time;
    logic                    in_on_time;
    logic [3:0]              nibble;

    logic [NUM_DIGITS-1:0]   an_nxt;
    logic [6:0]              seg_nxt;
    logic                    dp_nxt;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    assign slot_end = enable && (div_cnt == CNT_LAST);
    assign wrap     = slot_end && (digit_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt    <= '0;
            digit_idx  <= '0;
            frame_done <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            frame_done <= wrap;
            load_ack   <= wrap && pend_valid;
            if (slot_end) begin
                div_cnt   <= '0;
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
            end else if (enable) begin
                div_cnt <= div_cnt + CNT_W'(1);
            end
        end
    end

    // A load coinciding with the wrap lands in pending and waits for the next wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_lit   <= '0;
            pend_valid <= 1'b0;
            disp_value <= '0;
            disp_dp    <= '0;
            disp_lit   <= '0;
        end else begin
            if (wrap && pend_valid) begin
                disp_value <= pend_value;
                disp_dp    <= pend_dp;
                disp_lit   <= pend_lit;
            end
            if (load) begin
                pend_value <= value;
                pend_dp    <= dp_in;
                pend_lit   <= ~blank_mask;
                pend_valid <= 1'b1;
            end else if (wrap) begin
                pend_valid <= 1'b0;
            end
        end
    end

    // Full-width product keeps on_time exact up to 100 % duty.
    assign on_prod    = (PROD_W'(brightness) + PROD_W'(1)) * PROD_W'(CLK_DIV);
    assign on_time    = on_prod >> DUTY_BITS;
    assign in_on_time = PROD_W'(div_cnt) < on_time;
    assign nibble     = disp_value[{digit_idx, 2'b00} +: 4];

    always_comb begin
        an_nxt  = '1;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        if (enable && in_on_time && disp_lit[digit_idx]) begin
            an_nxt  = ~(NUM_DIGITS'(1) << digit_idx);
            seg_nxt = hex_to_seg(nibble);
            dp_nxt  = ~disp_dp[digit_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: a position-based reference model pushes
// expected pin values each clock, directed steps pop and compare them every cycle.
module tb_seg_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 8;
    localparam int DB  = 3;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_mask;
    logic [2:0]  brightness;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;
    logic        frame_done;
    logic        load_ack;

    always #5 clk = ~clk;

    seg_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(DIV), .DUTY_BITS(DB)) dut (
        .clk(clk), .rst(rst), .enable(enable), .value(value), .dp_in(dp_in),
        .blank_mask(blank_mask), .brightness(brightness), .load(load),
        .an(an), .seg(seg), .dp(dp), .digit_idx(digit_idx),
        .frame_done(frame_done), .load_ack(load_ack)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
        logic       fd;
        logic       ack;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state: t = enabled cycles since reset.
    int          t;
    logic        pv;
    logic [15:0] pval, dval;
    logic [3:0]  pdp, ddp, pbl, dbl;

    function automatic logic wrap_now();
        return enable && ((t % FRAME) == FRAME - 1);
    endfunction

    function automatic exp_t predict();
        exp_t e;
        int   slot, ph, on, tn;
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.idx = 2'd0;
        e.fd  = 1'b0;
        e.ack = 1'b0;
        if (!rst) begin
            slot = (t / DIV) % N;
            ph   = t % DIV;
            on   = ((int'(brightness) + 1) * DIV) >> DB;
            if (enable && ph < on && !dbl[slot]) begin
                e.an  = ~(4'b0001 << slot);
                e.seg = seg_tab[dval[4*slot +: 4]];
                e.dp  = ~ddp[slot];
            end
            e.fd  = wrap_now();
            e.ack = wrap_now() && pv;
            tn    = enable ? t + 1 : t;
            e.idx = 2'((tn / DIV) % N);
        end
        return e;
    endfunction

    always @(posedge clk) begin
        exp_q.push_back(predict());
        if (rst) begin
            t <= 0; pv <= 1'b0;
            pval <= '0; pdp <= '0; pbl <= '1;
            dval <= '0; ddp <= '0; dbl <= '1;
        end else begin
            if (wrap_now() && pv) begin
                dval <= pval; ddp <= pdp; dbl <= pbl;
            end
            if (load) begin
                pval <= value; pdp <= dp_in; pbl <= blank_mask; pv <= 1'b1;
            end else if (wrap_now()) begin
                pv <= 1'b0;
            end
            if (enable) t <= t + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_cycle(input exp_t e);
        chk("an", 32'(an), 32'(e.an));
        chk("seg", 32'(seg), 32'(e.seg));
        chk("dp", 32'(dp), 32'(e.dp));
        chk("digit_idx", 32'(digit_idx), 32'(e.idx));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
        chk("load_ack", 32'(load_ack), 32'(e.ack));
        chk("one_cold", 32'($countones(~an) <= 1), 32'd1);
    endtask

    task automatic tick();
        @(negedge clk);
        if (exp_q.size() > 0) check_cycle(exp_q.pop_front());
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value = v; dp_in = d; blank_mask = b; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_ack(input int max, input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            if (load_ack === 1'b1) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_fd(input int max, input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            if (frame_done === 1'b1) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_idx(input logic [1:0] target, input int max, input string tag);
        logic seen = (digit_idx === target);
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            if (digit_idx === target) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int n;
        int acks;
        rst = 1'b1; enable = 1'b1; load = 1'b0; value = '0;
        dp_in = '0; blank_mask = '0; brightness = 3'd7;
        run(3);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_idx", 32'(digit_idx), 32'd0);
        rst = 1'b0;
        run(10);

        pulse_load(16'h3A50, 4'b0000, 4'b0000);
        wait_ack(2*FRAME, "ack_3a50");
        wait_fd(FRAME + 4, "fd_seen");
        n = 0;
        do begin tick(); n++; end while (frame_done !== 1'b1 && n < 2*FRAME);
        chk("frame_period", 32'(n), 32'(FRAME));

        brightness = 3'd1;
        run(FRAME + 4);
        brightness = 3'd7;

        pulse_load(16'h7654, 4'b0001, 4'b0100);
        wait_ack(2*FRAME, "ack_7654");
        run(FRAME);
        pulse_load(16'hBA98, 4'b0000, 4'b0000);
        wait_ack(2*FRAME, "ack_ba98");
        run(FRAME);
        brightness = 3'd4;
        pulse_load(16'hFEDC, 4'b1010, 4'b0000);
        wait_ack(2*FRAME, "ack_fedc");
        run(FRAME);
        brightness = 3'd7;

        wait_idx(2'd1, FRAME, "reach_idx1");
        pulse_load(16'h1111, 4'b0000, 4'b0000);
        tick();
        pulse_load(16'h2222, 4'b0000, 4'b0000);
        acks = 0;
        for (int i = 0; i < FRAME + 8; i++) begin
            tick();
            if (load_ack === 1'b1) acks++;
        end
        chk("single_ack", 32'(acks), 32'd1);

        wait_fd(FRAME + 4, "fd_before_wrap_load");
        run(FRAME - 1);
        pulse_load(16'h5A69, 4'b0110, 4'b0000);
        chk("no_ack_same_wrap", 32'(load_ack), 32'd0);
        acks = 0;
        for (int i = 0; i < FRAME - 1; i++) begin
            tick();
            if (load_ack === 1'b1) acks++;
        end
        chk("no_early_ack", 32'(acks), 32'd0);
        wait_ack(3, "ack_after_wrap_load");

        wait_idx(2'd2, FRAME + 4, "reach_idx2");
        run(5);
        enable = 1'b0;
        run(20);
        chk("hold_idx", 32'(digit_idx), 32'd2);
        chk("hold_an", 32'(an), 32'hF);
        enable = 1'b1;
        n = 0;
        do begin tick(); n++; end while (digit_idx === 2'd2 && n < 20);
        chk("resume_len", 32'(n), 32'd3);

        wait_idx(2'd3, FRAME + 4, "reach_idx3");
        run(2);
        rst = 1'b1;
        tick();
        chk("mid_rst_an", 32'(an), 32'hF);
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        chk("mid_rst_idx", 32'(digit_idx), 32'd0);
        rst = 1'b0;
        run(FRAME + 8);
        pulse_load(16'h2222, 4'b0000, 4'b0000);
        wait_ack(2*FRAME, "ack_after_rst");
        run(FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Parametrised multiplexed seven-segment display driver, successor to the fixed 3-bit one-cold digit selector. Owns the digit scan timing: prescaled refresh counter, digit index with wrap, one-cold anode drive, hex-to-segment decode, per-digit decimal point and blanking, PWM brightness, and tear-free double-buffered value loading. Sits between the CPU/GEMM status registers and the board display pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16)
CLK_DIV, 100000, clock cycles per digit slot (>= 2^DUTY_BITS)
DUTY_BITS, 3, width of brightness control

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  1 = scanning; 0 = display dark, counters hold
value  in  4*NUM_DIGITS  hex nibbles; digit k = value[4k+3:4k]
dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
blank_mask  in  NUM_DIGITS  1 = digit k fully dark
brightness  in  DUTY_BITS  on-time level; 0 = minimum, all-ones = full
load  in  1  one-cycle strobe: capture value/dp_in/blank_mask into pending buffer
an  out  NUM_DIGITS  anode drive, active-low, one-cold or all-ones
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
digit_idx  out  clog2(NUM_DIGITS)  digit currently addressed
frame_done  out  1  one-cycle pulse on digit index wrap
load_ack  out  1  one-cycle pulse when pending buffer is committed to display buffer

Behaviour:
- Reset (sync, rst=1 at posedge): an = all 1s, seg = 7'h7F, dp = 1, digit_idx = 0, frame_done = 0, load_ack = 0, div_cnt = 0, pending and display buffers = 0, pending_valid = 0. Reset mid-frame aborts the scan; the next frame starts at digit 0, div_cnt 0.
- Prescaler: div_cnt counts 0..CLK_DIV-1 when enable=1. At div_cnt = CLK_DIV-1, div_cnt -> 0 and digit_idx increments. At digit_idx = NUM_DIGITS-1 it wraps to 0, and frame_done pulses for exactly that one cycle.
- enable=0: div_cnt and digit_idx hold; an = all 1s, dp = 1, seg = 7'h7F. Scanning resumes from the held position on the next cycle with enable=1.
- Double buffer:
  - load=1 copies inputs into the pending buffer and sets pending_valid.
  - A later load before commit overwrites the pending buffer (last wins).
  - Commit happens on the wrap cycle: display <= pending, pending_valid <= 0, load_ack pulses in the same cycle as frame_done.
  - If load and the wrap coincide, the new inputs are written to the pending buffer and committed at the next wrap. The display buffer is never changed mid-frame.
- Brightness: on_time = ((brightness+1) * CLK_DIV) >> DUTY_BITS, using a full-width multiply (no truncation before the shift). The anode is active only while div_cnt < on_time. brightness = all-ones gives on_time = CLK_DIV (100 % duty).
- Output stage: an/seg/dp are registered, with 1-cycle latency from (digit_idx, div_cnt, display buffer) to pins.
  - Active slot: an = ~(1 << digit_idx).
  - Off-time or blanked digit: an = all 1s, seg = 7'h7F, dp = 1.
  - digit_idx and frame_done are registered state, with no extra delay.
- Decode (active-low {g..a}): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex). dp = ~dp_display[digit_idx].
- At most one anode is low in any cycle. There is no glitch at a slot boundary, because the outputs are registered.

Test Plan:
- NUM_DIGITS=4, CLK_DIV=8, DUTY_BITS=3, brightness=7, enable=1. load value=16'h3A50 and wait for load_ack. Then, over a frame, an cycles E,D,B,7 (8 cycles each) with seg 40,12,08,30. frame_done pulses every 32 cycles.
- Same config, brightness=1 -> on_time=2. Each slot has an low for 2 cycles and high for 6, and seg=7F during the off-time.
- blank_mask=4'b0100, dp_in=4'b0001 -> digit 2 is fully dark (an=F). Digit 0 shows dp=0; the other digits show dp=1.
- load 16'h1111 at mid-frame (digit 1), then load 16'h2222 two cycles later. The display shows the old value until the wrap, then 2222. A single load_ack coincides with frame_done.
- Drop enable at digit 2, cycle 5, for 20 cycles. Outputs go dark and digit_idx stays 2. On re-enable, the slot finishes its remaining cycles before advancing.
- Assert rst at digit 3 of a scan. The next cycle shows an=F, seg=7F, digit_idx=0. After release, a blank display is shown until a new load commits at a wrap.
